mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (CPU, DMA) arbiter in front of a single-port
// synchronous memory. Each access is IDLE -> ACC -> RESP with fixed latency.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: alternate the winner on simultaneous
// requests (default build: CPU has fixed priority).
module mem_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    state_t            state, state_nxt;
    logic              owner;     // 0 = CPU, 1 = DMA
    logic              lat_we;
    logic              win;       // requester chosen this cycle if in IDLE
    logic              take;      // IDLE -> ACC this cycle
    logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_winner;

    // Remember who won the most recent access to alternate on ties
    always_ff @(posedge clk) begin
        if (!rst)
            last_winner <= 1'b1;
        else if (take)
            last_winner <= win;
    end
`endif

    // Next-state and winner selection
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win = dma_req & (~cpu_req | ~last_winner);
`else
        win = dma_req & ~cpu_req;
`endif
        case (state)
            IDLE: if (cpu_req || dma_req) begin
                state_nxt = ACC;
                take      = 1'b1;
            end
            ACC:     state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Latch the winner's request so input changes mid-access are ignored
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (take) begin
            owner     <= win;
            lat_we    <= win ? dma_we    : cpu_we;
            mem_addr  <= win ? dma_addr  : cpu_addr;
            mem_wdata <= win ? dma_wdata : cpu_wdata;
        end
    end

    // Keep the last read result per requester; writes leave it untouched
    always_ff @(posedge clk) begin
        if (!rst) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else if (state == RESP && !lat_we) begin
            if (owner) dma_rdata_q <= mem_rdata;
            else       cpu_rdata_q <= mem_rdata;
        end
    end

    // Read data is forwarded straight from memory in the ack cycle so it is
    // valid alongside ack; afterwards the held copy is shown.
    assign cpu_rdata = (state == RESP && !lat_we && !owner) ? mem_rdata : cpu_rdata_q;
    assign dma_rdata = (state == RESP && !lat_we &&  owner) ? mem_rdata : dma_rdata_q;

    assign mem_en  = (state == ACC);
    assign mem_we  = (state == ACC) && lat_we;
    assign cpu_gnt = (state == ACC)  && !owner;
    assign dma_gnt = (state == ACC)  &&  owner;
    assign cpu_ack = (state == RESP) && !owner;
    assign dma_ack = (state == RESP) &&  owner;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter, with a small synchronous
// memory model. Expectations follow MEM_ARB_ROUND_ROBIN_EN if defined.
module tb_mem_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;

    logic              clk, rst;
    logic              cpu_req, cpu_we, dma_req, dma_we;
    logic [ADDR_W-1:0] cpu_addr, dma_addr, mem_addr;
    logic [DATA_W-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              cpu_gnt, cpu_ack, dma_gnt, dma_ack;
    logic              mem_en, mem_we, busy;

    int n_chk = 0;
    int n_err = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one-cycle read latency; two locations preloaded in reset
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (!rst) begin
            mem[13'h1FFF] <= 8'h7E;
            mem[13'h010]  <= 8'h5A;
            mem_rdata     <= '0;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access by a lone requester, checked cycle by cycle
    task automatic do_acc(input bit d, input bit we, input logic [12:0] a,
                          input logic [7:0] wd, input logic [7:0] exp_rd,
                          input logic [7:0] exp_other);
        if (d) begin dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = wd; end
        else   begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
        step();
        chk("acc_mem_en",  32'(mem_en), 1);
        chk("acc_mem_we",  32'(mem_we), 32'(we));
        chk("acc_addr",    32'(mem_addr), 32'(a));
        if (we) chk("acc_wdata", 32'(mem_wdata), 32'(wd));
        chk("acc_gnt",     32'({cpu_gnt, dma_gnt}), d ? 1 : 2);
        chk("acc_no_ack",  32'({cpu_ack, dma_ack}), 0);
        step();
        chk("resp_ack",    32'({cpu_ack, dma_ack}), d ? 1 : 2);
        chk("resp_no_gnt", 32'({cpu_gnt, dma_gnt, mem_en, mem_we}), 0);
        chk("resp_addr",   32'(mem_addr), 32'(a));
        chk("resp_rdata",  32'(d ? dma_rdata : cpu_rdata), 32'(exp_rd));
        chk("resp_other",  32'(d ? cpu_rdata : dma_rdata), 32'(exp_other));
        if (d) dma_req = 0; else cpu_req = 0;
        step();
        chk("idle_busy",   32'({busy, cpu_ack, dma_ack}), 0);
        chk("idle_rdata",  32'(d ? dma_rdata : cpu_rdata), 32'(exp_rd));
    endtask

    initial begin
        bit rr;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        rst = 0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        step(); step();
        chk("rst_ctrl",  32'({busy, cpu_gnt, cpu_ack, dma_gnt, dma_ack, mem_en, mem_we}), 0);
        chk("rst_addr",  32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_rdata", 32'({cpu_rdata, dma_rdata}), 0);
        rst = 1;
        step();
        chk("idle_quiet", 32'({busy, mem_en}), 0);

        // CPU write, DMA read from top address, CPU read-back, CPU write to other address
        do_acc(0, 1, 13'h0A5,  8'h3C, 8'h00, 8'h00);
        do_acc(1, 0, 13'h1FFF, 8'h00, 8'h7E, 8'h00);
        do_acc(0, 0, 13'h0A5,  8'h00, 8'h3C, 8'h7E);
        do_acc(0, 1, 13'h100,  8'h11, 8'h3C, 8'h7E);

        // Inputs change during ACC; access in flight must not notice
        cpu_req = 1; cpu_we = 0; cpu_addr = 13'h010;
        step();
        chk("mid_gnt", 32'(cpu_gnt), 1);
        cpu_addr = 13'h020; cpu_we = 1; cpu_wdata = 8'hFF;
        step();
        chk("mid_addr",  32'(mem_addr), 32'h010);
        chk("mid_ack",   32'(cpu_ack), 1);
        chk("mid_rdata", 32'(cpu_rdata), 32'h5A);
        cpu_req = 0; cpu_we = 0;
        step();
        chk("mid_addr_idle", 32'(mem_addr), 32'h010);

        // Reset during ACC aborts; pending DMA request is then served
        dma_req = 1; dma_we = 0; dma_addr = 13'h1FFF;
        step();
        chk("abort_gnt", 32'(dma_gnt), 1);
        rst = 0;
        step();
        chk("abort_ctrl", 32'({busy, cpu_gnt, cpu_ack, dma_gnt, dma_ack, mem_en, mem_we}), 0);
        chk("abort_regs", 32'({mem_addr, mem_wdata}), 0);
        chk("abort_rdata", 32'({cpu_rdata, dma_rdata}), 0);
        rst = 1;
        step();
        chk("post_gnt",  32'({cpu_gnt, dma_gnt}), 1);
        chk("post_addr", 32'(mem_addr), 32'h1FFF);
        step();
        chk("post_ack",   32'({cpu_ack, dma_ack}), 1);
        chk("post_rdata", 32'(dma_rdata), 32'h7E);
        dma_req = 0;
        step();
        chk("post_idle", 32'(busy), 0);

        // Simultaneous continuous reads; cycle 0 is the IDLE cycle
        cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0A5;
        dma_req = 1; dma_we = 0; dma_addr = 13'h1FFF;
        for (int c = 1; c <= 12; c++) begin
            int ph;
            bit own;
            step();
            ph  = c % 3;
            own = rr ? ((c / 3) % 2 == 1) : 1'b0;
            chk($sformatf("sim_gnt_c%0d", c), 32'({cpu_gnt, dma_gnt}),
                (ph == 1) ? (own ? 1 : 2) : 0);
            chk($sformatf("sim_ack_c%0d", c), 32'({cpu_ack, dma_ack}),
                (ph == 2) ? (own ? 1 : 2) : 0);
            if (ph == 2)
                chk($sformatf("sim_rdata_c%0d", c),
                    32'(own ? dma_rdata : cpu_rdata), own ? 32'h7E : 32'h3C);
        end
        cpu_req = 0; dma_req = 0;
        step();
        chk("sim_end_idle", 32'({busy, mem_en}), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
